// File: rtl/cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI memory debug controller.
// Imported by the controller top and its RAM-port arbiter.
package cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    J_IDLE,
    J_PEND_RD,
    J_CAPTURE,
    J_PEND_WR
  } j_state_e;

  localparam int JDO_LD   = 17;
  localparam int JDO_CLR  = 25;
  localparam int JDO_A_LO = 26;
  localparam int JDO_A_HI = 33;
  localparam int JDO_RD   = 34;
  localparam int JDO_D_LO = 3;
  localparam int JDO_D_HI = 34;

  localparam logic GNT_CPU  = 1'b0;
  localparam logic GNT_JTAG = 1'b1;

endpackage

// File: rtl/cpu_ocimem_rr_arb.sv
// Two-requester alternating-priority arbiter for the debug RAM port.
// On a tie the side that did not win last time is granted.
module cpu_ocimem_rr_arb
  import cpu_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_cpu,
  input  logic req_jtag,
  output logic gnt_cpu,
  output logic gnt_jtag
);

  logic last_q;
  logic last_d;

  // Grant decision and remembered winner
  always_comb begin
    gnt_jtag = req_jtag & (~req_cpu | (last_q == GNT_CPU));
    gnt_cpu  = req_cpu & ~gnt_jtag;
    last_d   = last_q;
    if (gnt_jtag) begin
      last_d = GNT_JTAG;
    end else if (gnt_cpu) begin
      last_d = GNT_CPU;
    end
  end

  // Last-grant register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= GNT_CPU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cpu_ocimem_debug_ctrl.sv
// Sequences JTAG debug memory commands against the debug RAM and
// shares the RAM port with the CPU debug-slave interface.
module cpu_ocimem_debug_ctrl
  import cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  j_state_e          st_q, st_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              rd_ph_q, rd_ph_d;

  logic req_cpu, req_jtag;
  logic gnt_cpu, gnt_jtag;
  logic dec_a, dec_b, dec_n, cmd_any;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign req_cpu  = reset_n & (cpu_read | cpu_write) & ~rd_ph_q;
  assign req_jtag = reset_n & ((st_q == J_PEND_RD) | (st_q == J_PEND_WR));

  cpu_ocimem_rr_arb u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_cpu  (req_cpu),
    .req_jtag (req_jtag),
    .gnt_cpu  (gnt_cpu),
    .gnt_jtag (gnt_jtag)
  );

  assign dec_b   = take_action_ocimem_b;
  assign dec_a   = take_action_ocimem_a & ~take_action_ocimem_b;
  assign dec_n   = take_no_action_ocimem_a & ~take_action_ocimem_a
                 & ~take_action_ocimem_b;
  assign cmd_any = take_action_ocimem_a | take_action_ocimem_b
                 | take_no_action_ocimem_a;

  assign cpu_readdata  = ram_rdata;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

  // RAM port steering and CPU handshake
  always_comb begin
    ram_addr        = mon_a_q;
    ram_we          = 1'b0;
    ram_be          = 4'hF;
    ram_wdata       = mon_d_q;
    cpu_waitrequest = ~(rd_ph_q & reset_n);
    rd_ph_d         = 1'b0;
    if (gnt_cpu) begin
      ram_addr = cpu_address;
      if (cpu_write) begin
        ram_we          = 1'b1;
        ram_be          = cpu_byteenable;
        ram_wdata       = cpu_writedata;
        cpu_waitrequest = 1'b0;
      end else begin
        rd_ph_d = 1'b1;
      end
    end else if (gnt_jtag) begin
      ram_we = (st_q == J_PEND_WR);
    end
  end

  // JTAG command FSM next state and monitor registers
  always_comb begin
    st_d    = st_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    unique case (st_q)
      J_IDLE: begin
        unique case (1'b1)
          dec_b: begin
            mon_d_d = jdo[JDO_D_HI:JDO_D_LO];
            rdy_d   = 1'b0;
            st_d    = J_PEND_WR;
          end
          dec_a: begin
            if (jdo[JDO_LD]) begin
              mon_a_d = ADDR_W'(jdo[JDO_A_HI:JDO_A_LO]);
            end
            if (jdo[JDO_CLR]) begin
              err_d = 1'b0;
            end
            rdy_d = 1'b0;
            if (jdo[JDO_RD]) begin
              st_d = J_PEND_RD;
            end
          end
          dec_n: begin
            rdy_d = 1'b0;
            st_d  = J_PEND_RD;
          end
          default: ;
        endcase
      end
      J_PEND_RD: begin
        if (gnt_jtag) begin
          st_d = J_CAPTURE;
        end
      end
      J_CAPTURE: begin
        mon_d_d = ram_rdata;
        mon_a_d = mon_a_q + ADDR_W'(1);
        rdy_d   = 1'b1;
        st_d    = J_IDLE;
      end
      J_PEND_WR: begin
        if (gnt_jtag) begin
          mon_a_d = mon_a_q + ADDR_W'(1);
          rdy_d   = 1'b1;
          st_d    = J_IDLE;
        end
      end
      default: st_d = J_IDLE;
    endcase
    if (cmd_any && (st_q != J_IDLE)) begin
      err_d = 1'b1;
    end
  end

  // State and monitor register update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q    <= J_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ph_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rd_ph_q <= rd_ph_d;
    end
  end

endmodule

// File: tb/tb_cpu_ocimem_debug_ctrl.sv
// Self-checking bench for cpu_ocimem_debug_ctrl with a transaction-level
// model of the debug RAM, JTAG command sequencing and CPU access.
module tb_cpu_ocimem_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta = 1'b0, tbw = 1'b0, tn = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ocimem_debug_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_action_ocimem_b    (tbw),
    .take_no_action_ocimem_a (tn),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .ram_addr                (ram_addr),
    .ram_we                  (ram_we),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Debug RAM with one-cycle registered read
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {8'hA5, v, ~v, 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] sm [256];
  int          m_a, m_job, j0;
  logic [31:0] m_d, m_capv, m_rexp;
  bit          m_rdy, m_err, m_sec, m_tj, m_ok;
  bit          cw, jw, wj, wc, gj, gc;

  always_comb begin
    cw = (cpu_read || cpu_write) && !m_sec && reset_n;
    jw = (m_job == 1 || m_job == 2) && reset_n;
    wj = jw && (!cw || m_tj);
    wc = cw && !wj;
  end

  always @(posedge clk) begin
    gj = wj;
    gc = wc;
    j0 = m_job;
    if (!reset_n) begin
      m_a = 0; m_d = 0; m_rdy = 0; m_err = 0;
      m_job = 0; m_sec = 0; m_tj = 1; m_ok = 1;
    end else begin
      m_sec = 0;
      if (gc) begin
        m_tj = 1;
        if (cpu_write)
          sm[cpu_address] = merge(sm[cpu_address], cpu_writedata,
                                  cpu_byteenable);
        else begin
          m_sec = 1;
          m_rexp = sm[cpu_address];
        end
      end
      if (gj) begin
        m_tj = 0;
        if (j0 == 1) begin
          m_capv = sm[m_a];
          m_job = 3;
        end else begin
          sm[m_a] = m_d;
          m_a = (m_a + 1) % 256;
          m_rdy = 1;
          m_job = 0;
        end
      end else if (j0 == 3) begin
        m_d = m_capv;
        m_a = (m_a + 1) % 256;
        m_rdy = 1;
        m_job = 0;
      end
      if (ta || tbw || tn) begin
        if (j0 != 0) m_err = 1;
        else if (tbw) begin
          m_d = jdo[34:3]; m_rdy = 0; m_job = 2;
        end else if (ta) begin
          if (jdo[17]) m_a = int'(jdo[33:26]);
          if (jdo[25]) m_err = 0;
          m_rdy = 0;
          if (jdo[34]) m_job = 1;
        end else begin
          m_rdy = 0; m_job = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  bit          e_we, e_wait;
  always @(negedge clk) begin
    if (m_ok) begin
      e_we   = (wj && m_job == 2) || (wc && cpu_write);
      e_wait = !(reset_n && (m_sec || (wc && cpu_write)));
      chk("mondreg", MonDReg, m_d);
      chk("ready", 32'(monitor_ready), 32'(m_rdy));
      chk("error", 32'(monitor_error), 32'(m_err));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("waitreq", 32'(cpu_waitrequest), 32'(e_wait));
      if (reset_n && m_sec) chk("cpu_rdata", cpu_readdata, m_rexp);
      if (wj) chk("jtag_addr", 32'(ram_addr), 32'(m_a));
      if (wc) chk("cpu_addr", 32'(ram_addr), 32'(cpu_address));
      if (e_we && wj) begin
        chk("jtag_be", 32'(ram_be), 32'hF);
        chk("jtag_wdata", ram_wdata, m_d);
      end
      if (e_we && wc) begin
        chk("cpu_be", 32'(ram_be), 32'(cpu_byteenable));
        chk("cpu_wdata", ram_wdata, cpu_writedata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [37:0] j);
    jdo = j;
    ta  = (k == 0);
    tbw = (k == 1);
    tn  = (k == 2);
    tick();
    ta = 0; tbw = 0; tn = 0;
  endtask

  function automatic logic [37:0] jdo_a(input bit ld, input bit rd,
                                        input bit clr,
                                        input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[17] = ld;
    j[34] = rd;
    j[25] = clr;
    j[33:26] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      sm[i]  = init_word(i);
    end
    mem[8'h10] = 32'hDEADBEEF;
    sm[8'h10]  = 32'hDEADBEEF;

    repeat (2) tick();
    reset_n = 1;
    @(negedge clk);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_wait", 32'(cpu_waitrequest), 32'h1);
    tick();

    // Address load plus read of 0x10
    pulse(0, jdo_a(1, 1, 0, 8'h10));
    tick(); tick();
    @(negedge clk);
    chk("rd10_data", MonDReg, 32'hDEADBEEF);
    chk("rd10_ready", 32'(monitor_ready), 32'h1);
    tick();

    // Read-next from 0x11
    pulse(2, '0);
    tick(); tick();
    @(negedge clk);
    chk("rd11_data", MonDReg, init_word(8'h11));

    // Write at 0xFF then read-next wraps to 0x00
    tick();
    pulse(0, jdo_a(1, 0, 0, 8'hFF));
    pulse(1, jdo_b(32'h12345678));
    tick();
    @(negedge clk);
    chk("wrFF_ready", 32'(monitor_ready), 32'h1);
    chk("wrFF_mem", mem[8'hFF], 32'h12345678);
    tick();
    pulse(2, '0);
    tick(); tick();
    @(negedge clk);
    chk("wrap_rd00", MonDReg, init_word(0));
    tick();

    // Continuous CPU read racing a JTAG read of 0x01
    cpu_address = 8'h20;
    cpu_read = 1;
    pulse(2, '0);
    repeat (8) tick();
    cpu_read = 0;
    tick();
    @(negedge clk);
    chk("race_jrd", MonDReg, init_word(1));
    chk("race_ready", 32'(monitor_ready), 32'h1);
    tick();

    // Second command while a write is pending sets the error flag
    pulse(0, jdo_a(1, 0, 0, 8'h40));
    cpu_address = 8'h30;
    cpu_writedata = 32'h0BADF00D;
    cpu_byteenable = 4'hF;
    cpu_write = 1;
    pulse(1, jdo_b(32'hCAFE0001));
    pulse(1, jdo_b(32'h77777777));
    repeat (3) tick();
    cpu_write = 0;
    tick();
    @(negedge clk);
    chk("err_set", 32'(monitor_error), 32'h1);
    chk("err_mem40", mem[8'h40], 32'hCAFE0001);
    chk("err_mondreg", MonDReg, 32'hCAFE0001);
    chk("cpu_mem30", mem[8'h30], 32'h0BADF00D);
    tick();
    pulse(0, jdo_a(0, 0, 1, 8'h00));
    @(negedge clk);
    chk("err_clear", 32'(monitor_error), 32'h0);
    tick();

    // Reset while a write is pending
    pulse(0, jdo_a(1, 0, 0, 8'h50));
    pulse(1, jdo_b(32'h99999999));
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    @(negedge clk);
    chk("rstw_mem50", mem[8'h50], init_word(8'h50));
    chk("rstw_mondreg", MonDReg, 32'h0);
    tick();
    pulse(2, '0);
    tick(); tick();
    @(negedge clk);
    chk("rstw_rd00", MonDReg, init_word(0));
    chk("rstw_noerr", 32'(monitor_error), 32'h0);
    tick();

    // Partial-byte CPU write
    cpu_address = 8'h60;
    cpu_writedata = 32'hAABBCCDD;
    cpu_byteenable = 4'b0011;
    cpu_write = 1;
    @(negedge clk);
    chk("be_ram_be", 32'(ram_be), 32'h3);
    chk("be_wait", 32'(cpu_waitrequest), 32'h0);
    chk("be_we", 32'(ram_we), 32'h1);
    tick();
    cpu_write = 0;
    tick();
    @(negedge clk);
    chk("be_mem60", mem[8'h60], {init_word(8'h60) >> 16, 16'hCCDD});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
